// File: rtl/calc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : calc_pkg                                                      |
// | Purpose  : mode/op encodings and FSM state type for calc_seq_core        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package calc_pkg;

  localparam logic [1:0] MODE_ARITH = 2'd0;
  localparam logic [1:0] MODE_LOGIC = 2'd1;
  localparam logic [1:0] MODE_CMP   = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_NOT = 2'd3;

  localparam logic [1:0] OP_EQ = 2'd0;
  localparam logic [1:0] OP_GT = 2'd1;
  localparam logic [1:0] OP_LT = 2'd2;
  localparam logic [1:0] OP_NE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } calc_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_muldiv                                                    |
// | Purpose  : W-cycle shift-add multiplier / restoring divider engine       |
// |            (divider only when CALC_DIV_EN is defined)                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module seq_muldiv #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           go,
`ifdef CALC_DIV_EN
  input  logic           sel_div,
`endif
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           fin,
  output logic [2*W-1:0] prod
);

  localparam int c_cw = $clog2(W);
  localparam logic [c_cw-1:0] c_last = c_cw'(W - 1);

  // r_p: {accumulator, multiplier} for mul, {remainder, quotient} for div
  logic [2*W-1:0]  r_p;
  logic [W-1:0]    r_m;
  logic [c_cw-1:0] r_cnt;
  logic            r_active;

  logic [W:0]      w_msum;
  logic [2*W-1:0]  w_mnext;
  logic [2*W-1:0]  w_next;

  assign w_msum  = {1'b0, r_p[2*W-1:W]} + (r_p[0] ? {1'b0, r_m} : {(W+1){1'b0}});
  assign w_mnext = {w_msum, r_p[W-1:1]};

`ifdef CALC_DIV_EN
  logic           r_div;
  logic [W:0]     w_shift;
  logic [W:0]     w_dsub;
  logic           w_ge;
  logic [2*W-1:0] w_dnext;

  assign w_shift = {r_p[2*W-1:W], r_p[W-1]};
  assign w_dsub  = w_shift - {1'b0, r_m};
  assign w_ge    = w_shift[W] | ~w_dsub[W];
  assign w_dnext = w_ge ? {w_dsub[W-1:0], r_p[W-2:0], 1'b1}
                        : {w_shift[W-1:0], r_p[W-2:0], 1'b0};
  assign w_next  = r_div ? w_dnext : w_mnext;
`else
  assign w_next  = w_mnext;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p      <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
`ifdef CALC_DIV_EN
      r_div    <= 1'b0;
`endif
    end else if (go) begin
      r_cnt    <= '0;
      r_active <= 1'b1;
`ifdef CALC_DIV_EN
      r_div    <= sel_div;
      r_p      <= {{W{1'b0}}, sel_div ? a : b};
      r_m      <= sel_div ? b : a;
`else
      r_p      <= {{W{1'b0}}, b};
      r_m      <= a;
`endif
    end else if (r_active) begin
      r_p <= w_next;
      if (r_cnt == c_last) begin
        r_active <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // fin is high in the cycle whose closing edge performs the last step
  assign fin  = r_active && (r_cnt == c_last);
  assign prod = r_p;

endmodule
`default_nettype wire

// File: rtl/calc_seq_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : calc_seq_core                                                 |
// | Purpose  : clocked calculator datapath; CALC_DIV_EN enables the divider  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module calc_seq_core
  import calc_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic [1:0]     op,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           ovf,
  output logic           err,
  output logic [1:0]     mode_q,
  output logic [1:0]     op_q
);

  calc_state_t    r_state;
  logic [W-1:0]   r_x;
  logic [W-1:0]   r_y;
  logic [1:0]     r_mode;
  logic [1:0]     r_op;

  logic           w_need_iter;
  logic           w_go;
  logic           w_fin;
  logic [2*W-1:0] w_prod;
  logic [W:0]     w_sum;
  logic [W:0]     w_diff;
  logic [2*W-1:0] w_res;
  logic           w_ovf;
  logic           w_err;

`ifdef CALC_DIV_EN
  assign w_need_iter = (mode == MODE_ARITH) &&
                       ((op == OP_MUL) || ((op == OP_DIV) && (y != '0)));
`else
  assign w_need_iter = (mode == MODE_ARITH) && (op == OP_MUL);
`endif

  assign w_go = (r_state == ST_IDLE) && start && w_need_iter;

  // engine loads straight from the ports on the accepting edge
  seq_muldiv #(.W(W)) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .go      (w_go),
`ifdef CALC_DIV_EN
    .sel_div (op == OP_DIV),
`endif
    .a       (x),
    .b       (y),
    .fin     (w_fin),
    .prod    (w_prod)
  );

  assign w_sum  = {1'b0, r_x} + {1'b0, r_y};
  assign w_diff = {1'b0, r_x} - {1'b0, r_y};

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_err = 1'b0;
    case (r_mode)
      MODE_ARITH: begin
        case (r_op)
          OP_ADD: begin
            w_res = {{W{1'b0}}, w_sum[W-1:0]};
            w_ovf = w_sum[W];
          end
          OP_SUB: begin
            w_res = {{W{1'b0}}, w_diff[W-1:0]};
            w_ovf = w_diff[W];
          end
          OP_MUL: w_res = w_prod;
          OP_DIV: begin
`ifdef CALC_DIV_EN
            if (r_y == '0) begin
              w_res = {r_x, {W{1'b1}}};
              w_err = 1'b1;
            end else begin
              w_res = w_prod;
            end
`else
            w_err = 1'b1;
`endif
          end
        endcase
      end
      MODE_LOGIC: begin
        case (r_op)
          OP_AND: w_res = {{W{1'b0}}, r_x & r_y};
          OP_OR:  w_res = {{W{1'b0}}, r_x | r_y};
          OP_XOR: w_res = {{W{1'b0}}, r_x ^ r_y};
          OP_NOT: w_res = {{W{1'b0}}, ~r_x};
        endcase
      end
      MODE_CMP: begin
        case (r_op)
          OP_EQ: w_res = {{(2*W-1){1'b0}}, (r_x == r_y)};
          OP_GT: w_res = {{(2*W-1){1'b0}}, (r_x >  r_y)};
          OP_LT: w_res = {{(2*W-1){1'b0}}, (r_x <  r_y)};
          OP_NE: w_res = {{(2*W-1){1'b0}}, (r_x != r_y)};
        endcase
      end
      MODE_RSVD: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_mode  <= '0;
      r_op    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
      mode_q  <= '0;
      op_q    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_x     <= x;
            r_y     <= y;
            r_mode  <= mode;
            r_op    <= op;
            busy    <= 1'b1;
            r_state <= w_need_iter ? ST_ITER : ST_DONE;
          end
        end
        ST_ITER: begin
          if (w_fin) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          result  <= w_res;
          ovf     <= w_ovf;
          err     <= w_err;
          mode_q  <= r_mode;
          op_q    <= r_op;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_seq_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_calc_seq_core                                              |
// | Purpose  : directed self-checking bench for calc_seq_core (W=4)          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_calc_seq_core;

  localparam int W = 4;

  typedef struct {
    logic [1:0] mode;
    logic [1:0] op;
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] res;
    logic       ovf;
    logic       err;
    int         lat;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     mode = '0;
  logic [1:0]     op = '0;
  logic [W-1:0]   x = '0;
  logic [W-1:0]   y = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           ovf;
  logic           err;
  logic [1:0]     mode_q;
  logic [1:0]     op_q;

  int n_chk  = 0;
  int n_fail = 0;
  vec_t tbl[$];

  calc_seq_core #(.W(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .op     (op),
    .x      (x),
    .y      (y),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf),
    .err    (err),
    .mode_q (mode_q),
    .op_q   (op_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] m, input logic [1:0] o,
                              input logic [3:0] a, input logic [3:0] b,
                              input logic [7:0] r, input logic v, input logic e,
                              input int l);
    vec_t t;
    t.mode = m; t.op = o; t.x = a; t.y = b;
    t.res = r; t.ovf = v; t.err = e; t.lat = l;
    return t;
  endfunction

  // one start pulse, operands scrambled after acceptance, bounded wait for done
  task automatic run_op(input string tag, input vec_t v);
    int  cnt;
    bit  seen;
    @(negedge clk);
    mode = v.mode; op = v.op; x = v.x; y = v.y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; x = ~v.x; y = ~v.y;
    cnt = 0; seen = 0;
    while (!seen && cnt < 20) begin
      if (done) begin
        seen = 1;
      end else begin
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        cnt++;
      end
    end
    chk({tag, ".done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, ".latency"}, 32'(cnt), 32'(v.lat));
      chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, ".result"}, 32'(result), 32'(v.res));
      chk({tag, ".ovf"}, 32'(ovf), 32'(v.ovf));
      chk({tag, ".err"}, 32'(err), 32'(v.err));
      chk({tag, ".mode_q"}, 32'(mode_q), 32'(v.mode));
      chk({tag, ".op_q"}, 32'(op_q), 32'(v.op));
      @(negedge clk);
      chk({tag, ".done_pulse"}, 32'(done), 32'd0);
      chk({tag, ".result_held"}, 32'(result), 32'(v.res));
    end
  endtask

  initial begin
    int ndone;
    logic [7:0] rcap;

    tbl.push_back(mk(2'd0, 2'd0, 4'd9,  4'd8,  8'h01, 1'b1, 1'b0, 1));
    tbl.push_back(mk(2'd0, 2'd0, 4'd3,  4'd4,  8'h07, 1'b0, 1'b0, 1));
    tbl.push_back(mk(2'd0, 2'd1, 4'd3,  4'd5,  8'h0E, 1'b1, 1'b0, 1));
    tbl.push_back(mk(2'd0, 2'd1, 4'd9,  4'd4,  8'h05, 1'b0, 1'b0, 1));
    tbl.push_back(mk(2'd0, 2'd2, 4'd15, 4'd15, 8'hE1, 1'b0, 1'b0, 5));
    tbl.push_back(mk(2'd0, 2'd2, 4'd6,  4'd5,  8'h1E, 1'b0, 1'b0, 5));
    tbl.push_back(mk(2'd0, 2'd2, 4'd7,  4'd0,  8'h00, 1'b0, 1'b0, 5));
`ifdef CALC_DIV_EN
    tbl.push_back(mk(2'd0, 2'd3, 4'd13, 4'd4,  8'h13, 1'b0, 1'b0, 5));
    tbl.push_back(mk(2'd0, 2'd3, 4'd7,  4'd3,  8'h12, 1'b0, 1'b0, 5));
    tbl.push_back(mk(2'd0, 2'd3, 4'd15, 4'd1,  8'h0F, 1'b0, 1'b0, 5));
    tbl.push_back(mk(2'd0, 2'd3, 4'd13, 4'd0,  8'hDF, 1'b0, 1'b1, 1));
`else
    tbl.push_back(mk(2'd0, 2'd3, 4'd13, 4'd4,  8'h00, 1'b0, 1'b1, 1));
    tbl.push_back(mk(2'd0, 2'd3, 4'd13, 4'd0,  8'h00, 1'b0, 1'b1, 1));
`endif
    tbl.push_back(mk(2'd1, 2'd0, 4'hC,  4'hA,  8'h08, 1'b0, 1'b0, 1));
    tbl.push_back(mk(2'd1, 2'd1, 4'hC,  4'hA,  8'h0E, 1'b0, 1'b0, 1));
    tbl.push_back(mk(2'd1, 2'd2, 4'hA,  4'h6,  8'h0C, 1'b0, 1'b0, 1));
    tbl.push_back(mk(2'd1, 2'd3, 4'hA,  4'h3,  8'h05, 1'b0, 1'b0, 1));
    tbl.push_back(mk(2'd2, 2'd0, 4'd5,  4'd5,  8'h01, 1'b0, 1'b0, 1));
    tbl.push_back(mk(2'd2, 2'd1, 4'd5,  4'd5,  8'h00, 1'b0, 1'b0, 1));
    tbl.push_back(mk(2'd2, 2'd1, 4'd9,  4'd3,  8'h01, 1'b0, 1'b0, 1));
    tbl.push_back(mk(2'd2, 2'd2, 4'd3,  4'd9,  8'h01, 1'b0, 1'b0, 1));
    tbl.push_back(mk(2'd2, 2'd3, 4'd5,  4'd5,  8'h00, 1'b0, 1'b0, 1));
    tbl.push_back(mk(2'd3, 2'd2, 4'd7,  4'd1,  8'h00, 1'b0, 1'b1, 1));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.result", 32'(result), 32'd0);
    chk("rst.busy",   32'(busy),   32'd0);
    chk("rst.done",   32'(done),   32'd0);
    chk("rst.ovf",    32'(ovf),    32'd0);
    chk("rst.err",    32'(err),    32'd0);
    chk("rst.mode_q", 32'(mode_q), 32'd0);
    chk("rst.op_q",   32'(op_q),   32'd0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      run_op($sformatf("vec%0d", i), tbl[i]);
    end

    // start pulses during a multiply must be dropped
    @(negedge clk);
    mode = 2'd0; op = 2'd2; x = 4'd15; y = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; rcap = '0;
    for (int c = 0; c < 12; c++) begin
      if (done) begin
        ndone++;
        rcap = result;
      end
      if (c == 1 || c == 2) begin
        start = 1'b1; op = 2'd0; x = 4'd1; y = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("ignore.done_count", 32'(ndone), 32'd1);
    chk("ignore.result", 32'(rcap), 32'hE1);
    chk("ignore.op_q", 32'(op_q), 32'd2);

    // reset in the second ITER cycle of a multiply
    mode = 2'd0; op = 2'd2; x = 4'd3; y = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort.busy_iter", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort.result", 32'(result), 32'd0);
    chk("abort.busy",   32'(busy),   32'd0);
    chk("abort.done",   32'(done),   32'd0);
    chk("abort.ovf",    32'(ovf),    32'd0);
    chk("abort.err",    32'(err),    32'd0);
    chk("abort.mode_q", 32'(mode_q), 32'd0);
    chk("abort.op_q",   32'(op_q),   32'd0);
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort.no_done", 32'(ndone), 32'd0);
    run_op("post_abort_add", mk(2'd0, 2'd0, 4'd3, 4'd4, 8'h07, 1'b0, 1'b0, 1));
    run_op("post_abort_mul", mk(2'd0, 2'd2, 4'd6, 4'd5, 8'h1E, 1'b0, 1'b0, 5));

    // start held high: issue every second cycle
    @(negedge clk);
    mode = 2'd0; op = 2'd0; x = 4'd1; y = 4'd2; start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d.busy", c), 32'(busy), 32'((c % 2) == 0));
      chk($sformatf("b2b%0d.done", c), 32'(done), 32'((c % 2) == 1));
    end
    start = 1'b0;
    @(negedge clk);
    chk("b2b.idle_busy", 32'(busy), 32'd0);
    chk("b2b.idle_done", 32'(done), 32'd0);
    chk("b2b.result", 32'(result), 32'h03);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
